// File: rtl/fetch_jump_sequencer.sv
// Fetch sequencer: owns the PC, issues one imem request at a time and resolves JAL
// locally. Define FETCH_MISALIGN_TRAP_EN to trap misaligned targets instead of masking them.
module fetch_jump_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        link_valid,
  output logic [4:0]  link_rd,
  output logic [31:0] link_data,
  output logic        misalign_err
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        link_valid_q, link_valid_d;
  logic [4:0]  link_rd_q, link_rd_d;
  logic [31:0] link_data_q, link_data_d;

  logic        is_jal;
  logic [31:0] jal_imm;
  logic [31:0] jal_target;
  logic [31:0] seq_pc;
  logic        pc_upd;
  logic [31:0] new_pc;

  assign is_jal     = (instr_q[6:0] == 7'b1101111);
  assign jal_imm    = {{12{instr_q[31]}}, instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
  assign jal_target = instr_pc_q + jal_imm;
  assign seq_pc     = instr_pc_q + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
`endif

  always_comb begin
    // NOTE: every next-state value gets a default before any branch so no latch is inferred.
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    req_addr_d   = req_addr_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    link_valid_d = 1'b0;
    link_rd_d    = link_rd_q;
    link_data_d  = link_data_q;
    pc_upd       = 1'b0;
    new_pc       = pc_q;

    case (state_q)
      IDLE: begin
        if (!stall) begin
          state_d    = REQ;
          req_addr_d = pc_q;
        end
      end
      REQ: begin
        if (imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = IDLE;
          end else begin
            instr_d    = imem_rsp_data;
            instr_pc_d = req_addr_q;
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        if (instr_ready) begin
          state_d = IDLE;
          pc_upd  = 1'b1;
          if (is_jal) begin
            new_pc       = jal_target;
            link_valid_d = (instr_q[11:7] != 5'd0);
            link_rd_d    = instr_q[11:7];
            link_data_d  = seq_pc;
          end else begin
            new_pc = seq_pc;
          end
        end
      end
      HALT: ;
      default: state_d = IDLE;
    endcase

    // Redirect beats any JAL or sequential update; an in-flight request must still
    // finish its handshake, so its response is marked for dropping instead.
    if (redirect_valid) begin
      pc_upd       = 1'b1;
      new_pc       = redirect_pc;
      link_valid_d = 1'b0;
      link_rd_d    = link_rd_q;
      link_data_d  = link_data_q;
      instr_d      = instr_q;
      instr_pc_d   = instr_pc_q;
      case (state_q)
        REQ:  kill_d = 1'b1;
        WAIT: begin
          if (imem_rsp_valid) begin
            kill_d  = 1'b0;
            state_d = IDLE;
          end else begin
            kill_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_d = 1'b0;
    if (pc_upd) begin
      pc_d = new_pc;
      if (new_pc[1:0] != 2'b00) begin
        misalign_d   = 1'b1;
        link_valid_d = 1'b0;
      end
    end
    // A misaligned PC is never fetched; park until execute redirects us.
    if (state_d == IDLE && pc_d[1:0] != 2'b00) state_d = HALT;
`else
    if (pc_upd) pc_d = new_pc & ~32'h3;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      req_addr_q   <= 32'd0;
      instr_q      <= 32'd0;
      instr_pc_q   <= 32'd0;
      link_valid_q <= 1'b0;
      link_rd_q    <= 5'd0;
      link_data_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      req_addr_q   <= req_addr_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      link_valid_q <= link_valid_d;
      link_rd_q    <= link_rd_d;
      link_data_q  <= link_data_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end
  assign misalign_err = misalign_q;
`else
  assign misalign_err = 1'b0;
`endif

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = req_addr_q;
  assign instr_valid    = (state_q == HOLD);
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign link_valid     = link_valid_q;
  assign link_rd        = link_rd_q;
  assign link_data      = link_data_q;

endmodule

// File: tb/tb_fetch_jump_sequencer.sv
// Bench for fetch_jump_sequencer: directed vector table, corner-case sequences, then
// random traffic checked against an architectural PC-stream model.
module tb_fetch_jump_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        link_valid;
  logic [4:0]  link_rd;
  logic [31:0] link_data;
  logic        misalign_err;

  fetch_jump_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_ready(instr_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .link_valid(link_valid), .link_rd(link_rd),
    .link_data(link_data), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic [31:0] next_addr;
    logic        lv;
    logic [4:0]  rd;
    logic [31:0] ld;
  } vec_t;

  typedef struct {
    logic [31:0] word;
    logic        is_jal;
    logic [4:0]  rd;
    logic [31:0] off;
  } gen_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Program image: a deterministic function of the address, JAL offsets word aligned.
  function automatic gen_t gen(input logic [31:0] a);
    gen_t        g;
    logic [31:0] h;
    logic [20:0] imm;
    h = (a ^ 32'h5bd1_e995) * 32'h9e37_79b1;
    h = h ^ (h >> 15);
    g.is_jal = (h[2:1] == 2'b00);
    g.rd     = h[15:11];
    g.off    = (32'(h[10:5]) - 32'd32) << 2;
    imm      = g.off[20:0];
    if (g.is_jal) g.word = {imm[20], imm[10:1], imm[11], imm[19:12], g.rd, 7'b1101111};
    else          g.word = {h[31:7], 7'b0010011};
    return g;
  endfunction

  task automatic wait_req(output logic [31:0] addr, output logic saw_iv);
    saw_iv = 1'b0;
    addr   = 'x;
    for (int i = 0; i < 20; i++) begin
      if (imem_req_valid) begin
        addr = imem_req_addr;
        return;
      end
      if (instr_valid) saw_iv = 1'b1;
      step();
    end
  endtask

  task automatic serve(input logic [31:0] data);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
  endtask

  task automatic consume();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
  endtask

  vec_t        vecs [6];
  logic [31:0] a;
  logic        s;
  logic        bad;
  gen_t        g;
  logic [31:0] exp_pc;
  logic        exp_link_v;
  logic [4:0]  exp_rd;
  logic [31:0] exp_ld;
  logic        rsp_pend;
  int          rsp_cnt;
  logic [31:0] rsp_addr;
  logic        prev_stuck;
  logic [31:0] prev_addr;
  int          consumed;

  initial begin
    vecs[0] = '{32'h0000_0010, 32'h0080_00EF, 32'h0000_0018, 1'b1, 5'd1, 32'h0000_0014};
    vecs[1] = '{32'h0000_0000, 32'hFFDF_F06F, 32'hFFFF_FFFC, 1'b0, 5'd0, 32'h0};
    vecs[2] = '{32'h0000_0020, 32'h0010_0093, 32'h0000_0024, 1'b0, 5'd0, 32'h0};
    vecs[3] = '{32'h0000_0100, 32'hFF1F_F2EF, 32'h0000_00F0, 1'b1, 5'd5, 32'h0000_0104};
    vecs[4] = '{32'hFFFF_FFFC, 32'h0080_01EF, 32'h0000_0004, 1'b1, 5'd3, 32'h0000_0000};
    vecs[5] = '{32'h0000_0040, 32'h0000_80E7, 32'h0000_0044, 1'b0, 5'd0, 32'h0};

    rst_n = 1'b0; stall = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'd0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    #1;
    check("reset", {imem_req_valid, instr_valid, link_valid, misalign_err, imem_req_addr, instr_pc},
          96'd0);
    step(); step();
    rst_n = 1'b1;
    stall = 1'b0;

    // Straight-line fetch from reset.
    for (int k = 0; k < 3; k++) begin
      wait_req(a, s);
      check("seq_addr", a, 32'(k * 4));
      serve(NOP);
      check("seq_buf", {instr_valid, instr_pc, instr}, {1'b1, 32'(k * 4), NOP});
      stall = 1'b1;
      consume();
      stall = 1'b0;
    end
    stall = 1'b1;
    step();

    // Single-instruction vectors: redirect to pc, fetch word, consume, observe link and next fetch.
    for (int i = 0; i < 6; i++) begin
      stall = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = vecs[i].pc;
      step();
      redirect_valid = 1'b0;
      stall = 1'b0;
      wait_req(a, s);
      check("vec_start", {s, a}, {1'b0, vecs[i].pc});
      serve(vecs[i].word);
      check("vec_buf", {instr_valid, instr_pc, instr}, {1'b1, vecs[i].pc, vecs[i].word});
      stall = 1'b1;
      consume();
      if (vecs[i].lv) check("vec_link", {link_valid, link_rd, link_data}, {1'b1, vecs[i].rd, vecs[i].ld});
      else            check("vec_nolink", link_valid, 1'b0);
      stall = 1'b0;
      wait_req(a, s);
      check("vec_next", a, vecs[i].next_addr);
      serve(NOP);
    end

    // Redirect while waiting for a response: the stale word must never reach decode.
    stall = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    step();
    redirect_valid = 1'b0; stall = 1'b0;
    wait_req(a, s);
    check("wait_pre", a, 32'h80);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    step();
    imem_rsp_valid = 1'b0;
    wait_req(a, s);
    check("wait_kill", {s, a}, {1'b0, 32'h200});
    serve(NOP);
    check("wait_after", {instr_valid, instr_pc, instr}, {1'b1, 32'h200, NOP});

    // Redirect in the same cycle a JAL is consumed, then hold a request across stall/redirect.
    stall = 1'b1;
    consume();
    stall = 1'b0;
    wait_req(a, s);
    serve(32'h0080_00EF);
    check("jal_buf", {instr_valid, instr_pc}, {1'b1, 32'h204});
    stall = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
    step();
    instr_ready = 1'b0; redirect_valid = 1'b0;
    check("jal_redirect", {link_valid, instr_valid}, 2'b00);
    stall = 1'b0;
    wait_req(a, s);
    check("jal_redirect_addr", a, 32'h300);
    stall = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      redirect_valid = (i == 1);
      redirect_pc = 32'h400;
      step();
      if (!imem_req_valid || imem_req_addr !== 32'h300) bad = 1'b1;
    end
    redirect_valid = 1'b0;
    check("req_stable", bad, 1'b0);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0080_00EF;
    step();
    imem_rsp_valid = 1'b0;
    stall = 1'b0;
    wait_req(a, s);
    check("req_kill", {s, a}, {1'b0, 32'h400});

    // JAL to a half-word target.
    serve(NOP);
    stall = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0; stall = 1'b0;
    wait_req(a, s);
    serve(32'h0020_006F);
    stall = 1'b1;
    consume();
`ifdef FETCH_MISALIGN_TRAP_EN
    check("misalign_pulse", {misalign_err, link_valid}, 2'b10);
    stall = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (imem_req_valid || misalign_err) bad = 1'b1;
    end
    check("halt_quiet", bad, 1'b0);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    wait_req(a, s);
    check("halt_exit", a, 32'h40);
`else
    check("misalign_none", {misalign_err, link_valid}, 2'b00);
    stall = 1'b0;
    wait_req(a, s);
    check("misalign_mask", a, 32'h0);
`endif

    // Asynchronous reset in the middle of a transaction.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("mid_reset", {imem_req_valid, instr_valid, link_valid, misalign_err, imem_req_addr, instr_pc},
          96'd0);
    step();
    rst_n = 1'b1;

    // Random traffic against the architectural PC stream.
    exp_pc = 32'h0; exp_link_v = 1'b0; exp_rd = 5'd0; exp_ld = 32'd0;
    rsp_pend = 1'b0; rsp_cnt = 0; rsp_addr = 32'd0;
    prev_stuck = 1'b0; prev_addr = 32'd0; consumed = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (exp_link_v || link_valid)
        check("rnd_link", {link_valid, link_rd, link_data}, {exp_link_v, exp_rd, exp_ld});
      exp_link_v = 1'b0;
      check("rnd_misalign", misalign_err, 1'b0);
      if (prev_stuck) check("rnd_req_hold", {imem_req_valid, imem_req_addr}, {1'b1, prev_addr});
      if (imem_req_valid) check("rnd_one_outstanding", rsp_pend, 1'b0);

      stall          = ($urandom_range(3) == 0);
      imem_req_ready = ($urandom_range(9) < 6);
      instr_ready    = ($urandom_range(9) < 6);
      redirect_valid = ($urandom_range(24) == 0);
      redirect_pc    = 32'($urandom_range(255)) << 2;
      if ($urandom_range(3) == 0) redirect_pc = redirect_pc | 32'hFFFF_FC00;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (rsp_pend) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = gen(rsp_addr).word;
          rsp_pend       = 1'b0;
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        rsp_pend = 1'b1;
        rsp_cnt  = $urandom_range(3, 1);
        rsp_addr = imem_req_addr;
      end
      prev_stuck = imem_req_valid && !imem_req_ready;
      prev_addr  = imem_req_addr;

      if (redirect_valid) begin
        exp_pc = redirect_pc;
      end else if (instr_valid && instr_ready) begin
        consumed++;
        g = gen(exp_pc);
        check("rnd_stream", {instr_pc, instr}, {exp_pc, g.word});
        if (g.is_jal) begin
          exp_link_v = (g.rd != 5'd0);
          exp_rd     = g.rd;
          exp_ld     = exp_pc + 32'd4;
          exp_pc     = exp_pc + g.off;
        end else begin
          exp_pc = exp_pc + 32'd4;
        end
      end
      step();
    end
    check("rnd_progress", consumed > 50, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
